tpu_dma_engine: RTL and testbench
=================================

# tpu_dma_engine

DMA responder for the TPU controller's DMA command port. On `dma_start` it moves a block of data between the host streaming interface and the unified buffer (UB): host→UB (load) or UB→host (store). It reports progress to the controller via `dma_busy` and signals completion with a one-cycle `dma_done` pulse.

## Interface
- `UB_AW`, 8: UB word address width (matches `dma_ub_addr`).
- `DW`, 32: width of a host stream beat and of a UB word.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dma_start`  in  1  command strobe from controller; sampled only in IDLE.
- `dma_dir`  in  1  0 = host→UB, 1 = UB→host.
- `dma_ub_addr`  in  UB_AW  starting UB word address.
- `dma_length`  in  16  transfer length in elements.
- `dma_elem_sz`  in  2  element size: 00 = 1 B, 01 = 2 B, 10 = 4 B, 11 = illegal.
- `dma_busy`  out  1  high from the cycle after an accepted start until `dma_done`, inclusive.
- `dma_done`  out  1  one-cycle completion pulse.
- `dma_err`  out  1  one-cycle pulse on an illegal command.
- `h_in_data`  in  DW  host→UB beat.
- `h_in_valid`  in  1  host beat valid.
- `h_in_ready`  out  1  engine accepts a beat.
- `h_out_data`  out  DW  UB→host beat.
- `h_out_valid`  out  1  output beat valid.
- `h_out_ready`  in  1  host accepts a beat.
- `ub_wr_en`  out  1  UB write strobe.
- `ub_wr_addr`  out  UB_AW  UB write address.
- `ub_wr_data`  out  DW  UB write data.
- `ub_rd_en`  out  1  UB read strobe; data returns one cycle later.
- `ub_rd_addr`  out  UB_AW  UB read address.
- `ub_rd_data`  in  DW  UB read data, valid the cycle after `ub_rd_en`.

## Operation
- States: IDLE, LOAD, STORE, DONE.
- IDLE: on `dma_start`, latch all command fields.
  - Compute `beats = ((dma_length << dma_elem_sz) + 3) >> 2`, using an 18-bit intermediate; the result fits in 16 bits.
  - `dma_elem_sz` = 11: pulse `dma_err` next cycle, stay in IDLE, leave `dma_busy` low.
  - `beats` = 0: go to DONE.
  - Otherwise go to LOAD if `dma_dir` = 0, STORE if `dma_dir` = 1.
- LOAD:
  - `h_in_ready` = 1 while `beats_accepted < beats`.
  - Each handshake (`h_in_valid & h_in_ready`) registers `ub_wr_en` = 1, `ub_wr_addr` = current address and `ub_wr_data` = `h_in_data` for the next cycle. The address then increments.
  - After the final write is issued, go to DONE.
- STORE:
  - Issue `ub_rd_en` with incrementing addresses while `reads_issued < beats` and the 2-entry output FIFO has space, counting reads in flight.
  - Read data enters the FIFO; the FIFO head drives `h_out_data` / `h_out_valid`.
  - Once all beats have completed a host handshake, go to DONE.
- DONE: assert `dma_done` for one cycle, then return to IDLE.
- UB addresses wrap modulo 2^UB_AW; there is no wrap error.
- `dma_start` outside IDLE is ignored; there is no queuing.
- `h_in_ready` = 0 outside LOAD. The FIFO is empty outside STORE.
- Host stalls (`h_in_valid` low or `h_out_ready` low) hold all counters and addresses. No beat is lost or duplicated.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- Reset mid-transfer aborts immediately. No `dma_done` is issued, and the in-flight UB read is discarded.
- A start accepted at edge N gives `dma_busy` = 1 from cycle N+1.
- LOAD:
  - `h_in_ready` rises at N+1.
  - A handshake at edge K produces `ub_wr_en` during cycle K+1.
  - With `h_in_valid` held high, there is one beat per cycle.
  - `dma_done` occurs in the cycle after the last `ub_wr_en`.
- STORE:
  - The first `ub_rd_en` is in cycle N+1.
  - The first `h_out_valid` is in cycle N+2.
  - With `h_out_ready` held high, there is one beat per cycle.
  - `dma_done` occurs in the cycle after the last output handshake.
- Zero length: `dma_busy` = 1 at N+1, `dma_done` = 1 at N+1, IDLE at N+2.
- `dma_busy` falls in the cycle after `dma_done`. A new start is accepted in that cycle.

## Test plan
- Load, `length`=8, `elem_sz`=00 (2 beats), `addr`=0x10, data 0xA1A2A3A4 then 0xB1B2B3B4, valid held high → writes to 0x10 and 0x11 in consecutive cycles. `dma_done` occurs 1 cycle after the second write, and `dma_busy` spans start+1 through done.
- Store, `length`=4, `elem_sz`=10 (4 beats), `addr`=0xFE, UB model preloaded → reads 0xFE, 0xFF, 0x00, 0x01 in order. `h_out_data` matches the UB contents, and there are 4 back-to-back beats with `h_out_ready`=1.
- Store with `h_out_ready` toggling 1,0,0,1,… and load with `h_in_valid` gaps, `length`=5, `elem_sz`=01 (3 beats) → exactly 3 beats in order, with no drop or duplicate and data stable while stalled.
- `elem_sz`=11 → `dma_err` pulse. `dma_busy` stays 0, and there is no UB or host activity. `length`=0 → single-cycle busy plus `dma_done`.
- A `dma_start` pulse mid-transfer → ignored, and the original transfer completes unchanged.
- `rst_n` low during beat 2 of a 4-beat store → all outputs 0 immediately. A fresh load after reset works normally.

Source files
------------

// File: rtl/tpu_dma_engine.sv
// DMA responder: moves blocks between the host stream and the unified buffer.
// Loads write UB one beat per handshake; stores read UB through a 2-entry FIFO.
module tpu_dma_engine #(
   parameter int UB_AW = 8,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dma_start,
   input  logic             dma_dir,
   input  logic [UB_AW-1:0] dma_ub_addr,
   input  logic [15:0]      dma_length,
   input  logic [1:0]       dma_elem_sz,
   output logic             dma_busy,
   output logic             dma_done,
   output logic             dma_err,
   input  logic [DW-1:0]    h_in_data,
   input  logic             h_in_valid,
   output logic             h_in_ready,
   output logic [DW-1:0]    h_out_data,
   output logic             h_out_valid,
   input  logic             h_out_ready,
   output logic             ub_wr_en,
   output logic [UB_AW-1:0] ub_wr_addr,
   output logic [DW-1:0]    ub_wr_data,
   output logic             ub_rd_en,
   output logic [UB_AW-1:0] ub_rd_addr,
   input  logic [DW-1:0]    ub_rd_data
);

   typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

   state_t           state, state_nx;
   logic [17:0]      bytes_w;
   logic [15:0]      beats_c;
   logic [15:0]      beats_q;
   logic [15:0]      cnt_q;
   logic [15:0]      ocnt_q;
   logic [UB_AW-1:0] addr_q;
   logic [DW-1:0]    fifo_q [2];
   logic [1:0]       fcnt_q;
   logic             wp_q;
   logic             rp_q;
   logic             rd_pend_q;
   logic [2:0]       occ;
   logic             start_ok;
   logic             start_bad;
   logic             hs_in;
   logic             hs_out;
   logic             push;
   logic             pop_f;
   logic             rd_go;
   logic             last_out;

   assign bytes_w   = ({2'b00, dma_length} << dma_elem_sz) + 18'd3;
   assign beats_c   = 16'(bytes_w >> 2);
   assign start_ok  = (state == IDLE) && dma_start && (dma_elem_sz != 2'b11);
   assign start_bad = (state == IDLE) && dma_start && (dma_elem_sz == 2'b11);

   assign dma_busy   = (state != IDLE);
   assign dma_done   = (state == DONE);
   assign h_in_ready = (state == LOAD) && (cnt_q < beats_q);
   assign hs_in      = h_in_valid & h_in_ready;

   // Empty FIFO passes returning read data straight through to the host.
   assign h_out_valid = (fcnt_q != 2'd0) || rd_pend_q;
   assign h_out_data  = (fcnt_q != 2'd0) ? fifo_q[rp_q] :
                        (rd_pend_q ? ub_rd_data : '0);
   assign hs_out   = h_out_valid & h_out_ready;
   assign pop_f    = hs_out & (fcnt_q != 2'd0);
   assign push     = rd_pend_q & ~((fcnt_q == 2'd0) & hs_out);
   assign occ      = {1'b0, fcnt_q} + {2'b00, rd_pend_q} - {2'b00, hs_out};
   assign rd_go    = (state == STORE) && (cnt_q < beats_q) && (occ < 3'd2);
   assign last_out = hs_out && (ocnt_q == beats_q - 16'd1);

   assign ub_rd_en   = rd_go;
   assign ub_rd_addr = addr_q;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start_ok) begin
               if (beats_c == 16'd0) state_nx = DONE;
               else if (dma_dir)     state_nx = STORE;
               else                  state_nx = LOAD;
            end
         end
         LOAD:  if (cnt_q == beats_q) state_nx = DONE;
         STORE: if (last_out) state_nx = DONE;
         DONE:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         beats_q    <= '0;
         cnt_q      <= '0;
         ocnt_q     <= '0;
         addr_q     <= '0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         fcnt_q     <= '0;
         wp_q       <= 1'b0;
         rp_q       <= 1'b0;
         rd_pend_q  <= 1'b0;
         dma_err    <= 1'b0;
         ub_wr_en   <= 1'b0;
         ub_wr_addr <= '0;
         ub_wr_data <= '0;
      end else begin
         state     <= state_nx;
         dma_err   <= start_bad;
         ub_wr_en  <= hs_in;
         rd_pend_q <= rd_go;
         if (start_ok) begin
            beats_q <= beats_c;
            addr_q  <= dma_ub_addr;
            cnt_q   <= '0;
            ocnt_q  <= '0;
            fcnt_q  <= '0;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
         end else begin
            if (hs_in) begin
               ub_wr_addr <= addr_q;
               ub_wr_data <= h_in_data;
               addr_q     <= addr_q + 1'b1;
               cnt_q      <= cnt_q + 16'd1;
            end else if (rd_go) begin
               addr_q <= addr_q + 1'b1;
               cnt_q  <= cnt_q + 16'd1;
            end
            if (push) begin
               fifo_q[wp_q] <= ub_rd_data;
               wp_q         <= ~wp_q;
            end
            if (pop_f) rp_q <= ~rp_q;
            fcnt_q <= fcnt_q + {1'b0, push} - {1'b0, pop_f};
            if (hs_out) ocnt_q <= ocnt_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_tpu_dma_engine.sv
// Scoreboard bench for tpu_dma_engine: UB model, host drivers, timing checks.
module tb_tpu_dma_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dma_start, dma_dir;
   logic [7:0]  dma_ub_addr;
   logic [15:0] dma_length;
   logic [1:0]  dma_elem_sz;
   logic        dma_busy, dma_done, dma_err;
   logic [31:0] h_in_data;
   logic        h_in_valid, h_in_ready;
   logic [31:0] h_out_data;
   logic        h_out_valid, h_out_ready;
   logic        ub_wr_en, ub_rd_en;
   logic [7:0]  ub_wr_addr, ub_rd_addr;
   logic [31:0] ub_wr_data, ub_rd_data;

   tpu_dma_engine #(.UB_AW(8), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .dma_start(dma_start), .dma_dir(dma_dir),
      .dma_ub_addr(dma_ub_addr), .dma_length(dma_length),
      .dma_elem_sz(dma_elem_sz),
      .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err),
      .h_in_data(h_in_data), .h_in_valid(h_in_valid),
      .h_in_ready(h_in_ready),
      .h_out_data(h_out_data), .h_out_valid(h_out_valid),
      .h_out_ready(h_out_ready),
      .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr),
      .ub_wr_data(ub_wr_data),
      .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr),
      .ub_rd_data(ub_rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_wr[$];
   logic [7:0]  exp_rd[$];
   logic [31:0] exp_out[$];
   logic [31:0] ub_mem [256];

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int s_cyc, done_cyc, busy_n, busy_first;
   int wr_n, wr_first, wr_last, rd_n, rd_first;
   int out_n, out_first, out_last, ov_first, act_n;
   logic        prev_stall;
   logic [31:0] prev_data;
   logic        rdy_tog, rdy_hold;
   int          rdy_idx = 0;
   wr_t         e;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rdy_idx <= rdy_idx + 1;
   always @(posedge clk) if (ub_rd_en) ub_rd_data <= ub_mem[ub_rd_addr];

   assign h_out_ready = rdy_tog ? ((rdy_idx % 4 == 0) || (rdy_idx % 4 == 3))
                                : rdy_hold;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (dma_busy) begin
            if (busy_n == 0) busy_first = cyc;
            busy_n++;
         end
         if (dma_done) done_cyc = cyc;
         if (ub_wr_en) begin
            act_n++;
            if (wr_n == 0) wr_first = cyc;
            wr_last = cyc;
            wr_n++;
            if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
            else begin
               e = exp_wr.pop_front();
               chk("wr_addr", ub_wr_addr, e.a);
               chk("wr_data", ub_wr_data, e.d);
            end
         end
         if (ub_rd_en) begin
            act_n++;
            if (rd_n == 0) rd_first = cyc;
            rd_n++;
            if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
            else chk("rd_addr", ub_rd_addr, exp_rd.pop_front());
         end
         if (h_out_valid) begin
            if (ov_first < 0) ov_first = cyc;
            if (prev_stall) chk("stall_hold", h_out_data, prev_data);
            prev_stall = !h_out_ready;
            prev_data  = h_out_data;
            if (h_out_ready) begin
               if (out_n == 0) out_first = cyc;
               out_last = cyc;
               out_n++;
               if (exp_out.size() == 0) chk("out_extra", 1, 0);
               else chk("out_data", h_out_data, exp_out.pop_front());
            end
         end else begin
            if (prev_stall) chk("stall_drop", 0, 1);
            prev_stall = 1'b0;
         end
      end
   end

   task automatic clr();
      done_cyc = -1; busy_n = 0; busy_first = -1;
      wr_n = 0; wr_first = -1; wr_last = -1;
      rd_n = 0; rd_first = -1;
      out_n = 0; out_first = -1; out_last = -1; ov_first = -1;
   endtask

   task automatic start_cmd(input logic dir, input logic [7:0] a,
                            input logic [15:0] len, input logic [1:0] sz);
      dma_dir = dir; dma_ub_addr = a;
      dma_length = len; dma_elem_sz = sz;
      dma_start = 1'b1;
      @(posedge clk); #1;
      dma_start = 1'b0;
      s_cyc = cyc;
   endtask

   task automatic send(input logic [31:0] d, input int gap);
      int k;
      h_in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      h_in_valid = 1'b1;
      h_in_data  = d;
      k = 0;
      @(negedge clk);
      while (!h_in_ready && k < 50) begin @(negedge clk); k++; end
      if (!h_in_ready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      h_in_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (done_cyc < 0 && k < budget) begin @(negedge clk); k++; end
      if (done_cyc < 0) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; dma_start = 1'b0; dma_dir = 1'b0;
      dma_ub_addr = '0; dma_length = '0; dma_elem_sz = '0;
      h_in_data = '0; h_in_valid = 1'b0;
      rdy_tog = 1'b0; rdy_hold = 1'b1; ub_rd_data = '0;
      act_n = 0; prev_stall = 1'b0; prev_data = '0;
      for (int i = 0; i < 256; i++) ub_mem[i] = 32'hC0DE_0000 + i;
      clr();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctl", {dma_busy, dma_done, dma_err, h_in_ready,
                      h_out_valid, ub_wr_en, ub_rd_en}, 0);
      chk("rst_wr_addr", ub_wr_addr, 0);
      chk("rst_rd_addr", ub_rd_addr, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // load, 2 beats, valid held high
      clr();
      exp_wr.push_back('{8'h10, 32'hA1A2A3A4});
      exp_wr.push_back('{8'h11, 32'hB1B2B3B4});
      start_cmd(1'b0, 8'h10, 16'd8, 2'b00);
      send(32'hA1A2A3A4, 0);
      send(32'hB1B2B3B4, 0);
      wait_done(20);
      chk("t1_wr_n", wr_n, 2);
      chk("t1_wr_first", wr_first, s_cyc + 1);
      chk("t1_wr_consec", wr_last - wr_first, 1);
      chk("t1_done", done_cyc, wr_last + 1);
      chk("t1_busy_first", busy_first, s_cyc);
      chk("t1_busy_len", busy_n, done_cyc - s_cyc + 1);
      chk("t1_sb", exp_wr.size(), 0);

      // store, 4 beats across the address wrap
      clr();
      ub_mem[8'hFE] = 32'h1111_00FE; ub_mem[8'hFF] = 32'h2222_00FF;
      ub_mem[8'h00] = 32'h3333_0000; ub_mem[8'h01] = 32'h4444_0001;
      foreach (ub_mem[i]) if (i == 254 || i == 255 || i == 0 || i == 1) ;
      exp_rd.push_back(8'hFE); exp_rd.push_back(8'hFF);
      exp_rd.push_back(8'h00); exp_rd.push_back(8'h01);
      exp_out.push_back(32'h1111_00FE); exp_out.push_back(32'h2222_00FF);
      exp_out.push_back(32'h3333_0000); exp_out.push_back(32'h4444_0001);
      start_cmd(1'b1, 8'hFE, 16'd4, 2'b10);
      wait_done(30);
      chk("t2_out_n", out_n, 4);
      chk("t2_rd_first", rd_first, s_cyc);
      chk("t2_ov_first", ov_first, s_cyc + 1);
      chk("t2_b2b", out_last - out_first, 3);
      chk("t2_done", done_cyc, out_last + 1);
      chk("t2_sb", exp_out.size() + exp_rd.size(), 0);

      // store with host backpressure, 3 beats
      clr();
      for (int i = 0; i < 3; i++) begin
         exp_rd.push_back(8'h40 + 8'(i));
         exp_out.push_back(ub_mem[8'h40 + i]);
      end
      rdy_tog = 1'b1;
      start_cmd(1'b1, 8'h40, 16'd5, 2'b01);
      wait_done(60);
      rdy_tog = 1'b0;
      chk("t3_out_n", out_n, 3);
      chk("t3_sb", exp_out.size() + exp_rd.size(), 0);
      chk("t3_done", done_cyc, out_last + 1);

      // load with valid gaps and a stray start mid-transfer
      clr();
      exp_wr.push_back('{8'h80, 32'hD000_0001});
      exp_wr.push_back('{8'h81, 32'hD000_0002});
      exp_wr.push_back('{8'h82, 32'hD000_0003});
      start_cmd(1'b0, 8'h80, 16'd5, 2'b01);
      send(32'hD000_0001, 0);
      send(32'hD000_0002, 2);
      dma_dir = 1'b1; dma_ub_addr = 8'h33; dma_length = 16'd9;
      dma_start = 1'b1;
      @(posedge clk); #1;
      dma_start = 1'b0;
      send(32'hD000_0003, 1);
      wait_done(30);
      chk("t4_wr_n", wr_n, 3);
      chk("t4_no_rd", rd_n, 0);
      chk("t4_done", done_cyc, wr_last + 1);
      chk("t4_sb", exp_wr.size(), 0);

      // illegal element size
      clr();
      begin
         int a0;
         a0 = act_n;
         start_cmd(1'b0, 8'h05, 16'd10, 2'b11);
         @(negedge clk);
         chk("err_pulse", dma_err, 1);
         chk("err_busy", dma_busy, 0);
         chk("err_host", {h_in_ready, h_out_valid}, 0);
         @(negedge clk);
         chk("err_once", dma_err, 0);
         chk("err_busy2", dma_busy, 0);
         chk("err_act", act_n - a0, 0);
      end
      @(posedge clk); #1;

      // zero length
      clr();
      start_cmd(1'b0, 8'h00, 16'd0, 2'b10);
      @(negedge clk);
      chk("z_busy", dma_busy, 1);
      chk("z_done", dma_done, 1);
      @(negedge clk);
      chk("z_idle", {dma_busy, dma_done}, 0);
      @(posedge clk); #1;

      // reset during beat 2 of a 4-beat store
      clr();
      for (int i = 0; i < 4; i++) begin
         exp_rd.push_back(8'h20 + 8'(i));
         exp_out.push_back(ub_mem[8'h20 + i]);
      end
      start_cmd(1'b1, 8'h20, 16'd4, 2'b10);
      begin
         int k;
         k = 0;
         while (out_n < 1 && k < 20) begin @(negedge clk); #1; k++; end
         chk("r_beat1", out_n, 1);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("r_ctl", {dma_busy, dma_done, dma_err, h_in_ready,
                    h_out_valid, ub_wr_en, ub_rd_en}, 0);
      chk("r_hout", h_out_data, 0);
      exp_rd.delete(); exp_out.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("r_no_done", done_cyc, -1);
      chk("r_out_n", out_n, 1);

      // fresh load after reset
      clr();
      exp_wr.push_back('{8'h55, 32'h1234_5678});
      start_cmd(1'b0, 8'h55, 16'd4, 2'b00);
      send(32'h1234_5678, 0);
      wait_done(20);
      chk("f_wr_n", wr_n, 1);
      chk("f_done", done_cyc, wr_last + 1);
      chk("f_no_out", out_n, 0);
      chk("f_sb", exp_wr.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
